// File: rtl/fir_coeff_ctrl_if.sv
// Coefficient-load AXI-Stream channel between a coefficient source and fir_coeff_ctrl.
interface fir_coeff_ctrl_if #(
  parameter int COEFF_WIDTH = 24
);
  logic [COEFF_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fir_coeff_ctrl.sv
// Shadow/active coefficient bank controller: loads a set into shadow, checks its
// length, then commits it atomically on a frame boundary or on command.
//
// state   | meaning
// IDLE    | waiting for tap 0 of a new set
// LOAD    | accepting taps 1..NUM_TAPS-1 into shadow
// DRAIN   | over-long set, discarding beats up to tlast
// PENDING | complete set held in shadow, waiting for commit condition
module fir_coeff_ctrl #(
  parameter int                   COEFF_WIDTH = 24,
  parameter int                   NUM_TAPS    = 15,
  parameter int                   RESET_TAP   = 0,
  parameter logic [COEFF_WIDTH-1:0] RESET_VALUE = 24'h400000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  fir_coeff_ctrl_if.slave                 coef,
  input  logic                            frame_tvalid,
  input  logic                            frame_tready,
  input  logic                            frame_tlast,
  input  logic                            commit_mode,
  input  logic                            err_clr,
  output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeffs,
  output logic                            bank_sel,
  output logic                            pending,
  output logic                            swap_pulse,
  output logic                            err_len
);

  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    DRAIN   = 2'd2,
    PENDING = 2'd3
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [COEFF_WIDTH-1:0] shadow [NUM_TAPS];
  logic                   tready;
  logic                   beat;
  logic                   frame_event;
  logic                   at_last;

  assign coef.tready = tready;
  assign beat        = coef.tvalid & tready;
  assign frame_event = frame_tvalid & frame_tready & frame_tlast;
  assign at_last     = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      tready     <= 1'b0;
      pending    <= 1'b0;
      swap_pulse <= 1'b0;
      err_len    <= 1'b0;
      bank_sel   <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++)
        coeffs[i*COEFF_WIDTH +: COEFF_WIDTH] <= (i == RESET_TAP) ? RESET_VALUE : '0;
    end else begin
      swap_pulse <= 1'b0;
      // A length error raised below in the same cycle overrides this clear.
      if (err_clr)
        err_len <= 1'b0;

      case (state)
        IDLE: begin
          tready <= 1'b1;
          if (beat) begin
            shadow[0] <= coef.tdata;
            if (coef.tlast) begin
              err_len <= 1'b1;
              idx     <= '0;
            end else begin
              idx   <= IDX_W'(1);
              state <= LOAD;
            end
          end
        end

        LOAD: begin
          if (beat) begin
            shadow[idx] <= coef.tdata;
            if (coef.tlast && at_last) begin
              state   <= PENDING;
              tready  <= 1'b0;
              pending <= 1'b1;
            end else if (coef.tlast) begin
              err_len <= 1'b1;
              idx     <= '0;
              state   <= IDLE;
            end else if (at_last) begin
              err_len <= 1'b1;
              state   <= DRAIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        DRAIN: begin
          if (beat && coef.tlast) begin
            idx   <= '0;
            state <= IDLE;
          end
        end

        PENDING: begin
          if (commit_mode || frame_event) begin
            for (int i = 0; i < NUM_TAPS; i++)
              coeffs[i*COEFF_WIDTH +: COEFF_WIDTH] <= shadow[i];
            bank_sel   <= ~bank_sel;
            swap_pulse <= 1'b1;
            pending    <= 1'b0;
            tready     <= 1'b1;
            idx        <= '0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
